// File: rtl/ula_registradores_if.sv
// Command/operand and result bundle for the operand register bank.
//   tx      command code (0 CLEAR, 1 LOAD, 2 HOLD, 3 ADD, 4 SUB, 5 MUL, others HOLD)
//   entrada operand from the memory stage, aligned with the decoded LOAD
//   x, y    most recent / previous loaded operand
//   z       result register
//   flag    carry / borrow / multiply overflow of the last completed operation
//   busy    multiply iterating
//   done    one-cycle pulse after a result write
interface ula_registradores_if;
   logic [3:0] tx;
   logic [3:0] entrada;
   logic [3:0] x;
   logic [3:0] y;
   logic [3:0] z;
   logic       flag;
   logic       busy;
   logic       done;

   modport master (
      output tx, entrada,
      input  x, y, z, flag, busy, done
   );

   modport slave (
      input  tx, entrada,
      output x, y, z, flag, busy, done
   );
endinterface

// File: rtl/ula_registradores.sv
// Operand register bank and 4-bit arithmetic unit (add, subtract, shift-add
// multiply) downstream of the operand memory stage.
// Ports:
//   clock    rising-edge clock shared with the memory stage
//   reset_n  asynchronous active-low reset
//   bus      slave side of ula_registradores_if (tx/entrada in, results out)
module ula_registradores (
   input  logic                  clock,
   input  logic                  reset_n,
   ula_registradores_if.slave    bus
);

   localparam int unsigned W  = 4;
   localparam int unsigned PW = 8;
   localparam int unsigned CW = 2;

   localparam logic [0:0] S_IDLE    = 1'b0;
   localparam logic [0:0] S_MUL_RUN = 1'b1;

   localparam logic [W-1:0] CMD_CLEAR = 4'd0;
   localparam logic [W-1:0] CMD_LOAD  = 4'd1;
   localparam logic [W-1:0] CMD_ADD   = 4'd3;
   localparam logic [W-1:0] CMD_SUB   = 4'd4;
   localparam logic [W-1:0] CMD_MUL   = 4'd5;

   localparam logic [CW-1:0] LAST_ITER = 2'd3;

   logic [0:0]    state_q, state_n;
   logic [W-1:0]  tx_d;
   logic [W-1:0]  x_q, x_n;
   logic [W-1:0]  y_q, y_n;
   logic [W-1:0]  z_q, z_n;
   logic          flag_q, flag_n;
   logic          busy_q, busy_n;
   logic          done_q, done_n;
   logic [CW-1:0] cnt_q, cnt_n;
   logic [PW-1:0] prod_q, prod_n;
   logic [PW-1:0] mcand_q, mcand_n;
   logic [W-1:0]  mplier_q, mplier_n;
   logic [PW-1:0] prod_sum;

   // State and datapath registers
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= S_IDLE;
         tx_d     <= '0;
         x_q      <= '0;
         y_q      <= '0;
         z_q      <= '0;
         flag_q   <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         cnt_q    <= '0;
         prod_q   <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
      end else begin
         state_q  <= state_n;
         tx_d     <= bus.tx;
         x_q      <= x_n;
         y_q      <= y_n;
         z_q      <= z_n;
         flag_q   <= flag_n;
         busy_q   <= busy_n;
         done_q   <= done_n;
         cnt_q    <= cnt_n;
         prod_q   <= prod_n;
         mcand_q  <= mcand_n;
         mplier_q <= mplier_n;
      end
   end

   // Partial product including this iteration's conditional add
   always_comb begin
      prod_sum = prod_q;
      if (mplier_q[0]) prod_sum = prod_q + mcand_q;
   end

   // Next-state and datapath decode of the delayed command
   always_comb begin
      state_n  = state_q;
      x_n      = x_q;
      y_n      = y_q;
      z_n      = z_q;
      flag_n   = flag_q;
      busy_n   = busy_q;
      done_n   = 1'b0;
      cnt_n    = cnt_q;
      prod_n   = prod_q;
      mcand_n  = mcand_q;
      mplier_n = mplier_q;

      case (state_q)
         S_IDLE: begin
            case (tx_d)
               CMD_CLEAR: begin
                  x_n    = '0;
                  y_n    = '0;
                  z_n    = '0;
                  flag_n = 1'b0;
               end
               CMD_LOAD: begin
                  y_n = x_q;
                  x_n = bus.entrada;
               end
               CMD_ADD: begin
                  {flag_n, z_n} = 5'(y_q) + 5'(x_q);
                  done_n        = 1'b1;
               end
               CMD_SUB: begin
                  z_n    = y_q - x_q;
                  flag_n = (y_q < x_q);
                  done_n = 1'b1;
               end
               CMD_MUL: begin
                  state_n  = S_MUL_RUN;
                  busy_n   = 1'b1;
                  prod_n   = '0;
                  mcand_n  = PW'(y_q);
                  mplier_n = x_q;
                  cnt_n    = '0;
               end
               default: ;
            endcase
         end

         S_MUL_RUN: begin
            if (tx_d == CMD_CLEAR) begin
               // Abort: no result write, no done pulse
               state_n = S_IDLE;
               busy_n  = 1'b0;
               x_n     = '0;
               y_n     = '0;
               z_n     = '0;
               flag_n  = 1'b0;
            end else begin
               prod_n   = prod_sum;
               mcand_n  = mcand_q << 1;
               mplier_n = mplier_q >> 1;
               cnt_n    = cnt_q + 2'd1;
               if (cnt_q == LAST_ITER) begin
                  z_n     = prod_sum[W-1:0];
                  flag_n  = |prod_sum[PW-1:W];
                  busy_n  = 1'b0;
                  done_n  = 1'b1;
                  state_n = S_IDLE;
               end
            end
         end

         default: state_n = S_IDLE;
      endcase
   end

   assign bus.x    = x_q;
   assign bus.y    = y_q;
   assign bus.z    = z_q;
   assign bus.flag = flag_q;
   assign bus.busy = busy_q;
   assign bus.done = done_q;

endmodule
